// File: rtl/da_matvec_param_if.sv
// Bus bundle for da_matvec_param: start/done handshake, packed sample vector,
// coefficient write port, busy/result outputs and FSM state for debug.
`timescale 1ns/1ps
interface da_matvec_param_if #(
    parameter int N  = 8,
    parameter int XW = 8,
    parameter int CW = 4
);
    localparam int YW = XW + CW + $clog2(N);
    localparam int RW = $clog2(N);

    logic            start;
    logic [N*XW-1:0] x_in;
    logic            coef_we;
    logic [RW-1:0]   coef_row;
    logic [RW-1:0]   coef_col;
    logic [CW-1:0]   coef_data;
    logic            busy;
    logic            done;
    logic [N*YW-1:0] y_out;
    logic [1:0]      dbg_state;

    modport master (
        output start, x_in, coef_we, coef_row, coef_col, coef_data,
        input  busy, done, y_out, dbg_state
    );

    modport slave (
        input  start, x_in, coef_we, coef_row, coef_col, coef_data,
        output busy, done, y_out, dbg_state
    );
endinterface

// File: rtl/da_matvec_param.sv
// Distributed-arithmetic Y = D*X engine, bit-serial over X (LSB first), N channels.
// Optional macro DA_LUTREG_EN adds a register between the partial-sum adder and the accumulators.
`timescale 1ns/1ps
module da_matvec_param #(
    parameter int N  = 8,
    parameter int XW = 8,
    parameter int CW = 4
) (
    input logic             clk,
    input logic             reset,
    da_matvec_param_if.slave bus
);
    localparam int YW = XW + CW + $clog2(N);
    localparam int G  = N / 4;
`ifdef DA_LUTREG_EN
    localparam int LAST = XW;
`else
    localparam int LAST = XW - 1;
`endif
    localparam int CNTW = $clog2(LAST + 1);
    localparam logic [CNTW-1:0] LAST_C = CNTW'(LAST);
    localparam logic [CNTW-1:0] SIGN_J = CNTW'(XW - 1);

    // Handshake: start is sampled only in IDLE/DONE; busy is high for the whole
    // SHIFT phase; done rises with a valid y_out and holds until the next start.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [CW-1:0] r_coef [N][N];
    logic [XW-1:0]        r_xsh  [N];
    logic signed [YW-1:0] r_acc  [N];
    logic signed [YW-1:0] r_y    [N];
    logic [CNTW-1:0]      r_cnt;

    logic signed [YW-1:0] w_lut     [N][G][16];
    logic signed [YW-1:0] w_p       [N];
    logic signed [YW-1:0] w_acc_p   [N];
    logic signed [YW-1:0] w_acc_nxt [N];
    logic                 w_acc_en;
    logic [CNTW-1:0]      w_j;
    logic                 w_last;
    logic                 w_launch;

    assign w_last   = (r_cnt == LAST_C);
    assign w_launch = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.start) w_state_nxt = S_SHIFT;
            S_SHIFT:        if (w_last)    w_state_nxt = S_DONE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    // Partial-sum tables: entry e of group g in row k sums D[k][4g+b] for each set bit b of e.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            for (int g = 0; g < G; g++) begin
                for (int e = 0; e < 16; e++) begin
                    w_lut[k][g][e] = '0;
                    for (int b = 0; b < 4; b++) begin
                        if (e[b]) w_lut[k][g][e] = w_lut[k][g][e] + YW'(r_coef[k][4*g+b]);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_p[k] = '0;
            for (int g = 0; g < G; g++) begin
                w_p[k] = w_p[k] + w_lut[k][g][{r_xsh[4*g+3][0], r_xsh[4*g+2][0],
                                               r_xsh[4*g+1][0], r_xsh[4*g][0]}];
            end
        end
    end

`ifdef DA_LUTREG_EN
    logic signed [YW-1:0] r_p [N];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) r_p[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) r_p[k] <= w_p[k];
        end
    end

    // The first SHIFT cycle only fills r_p, so the accumulator lags the counter by one.
    assign w_acc_en = (r_cnt != '0);
    assign w_j      = r_cnt - CNTW'(1);
    assign w_acc_p  = r_p;
`else
    assign w_acc_en = 1'b1;
    assign w_j      = r_cnt;
    assign w_acc_p  = w_p;
`endif

    // The sign plane carries negative weight in two's complement, hence the subtraction.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_acc_nxt[k] = r_acc[k];
            if (w_acc_en) begin
                if (w_j == SIGN_J) w_acc_nxt[k] = r_acc[k] - (w_acc_p[k] <<< w_j);
                else               w_acc_nxt[k] = r_acc[k] + (w_acc_p[k] <<< w_j);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                r_xsh[i] <= '0;
                r_acc[i] <= '0;
                r_y[i]   <= '0;
            end
        end else if (w_launch) begin
            r_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                r_xsh[i] <= bus.x_in[i*XW +: XW];
                r_acc[i] <= '0;
            end
        end else if (r_state == S_SHIFT) begin
            r_cnt <= r_cnt + CNTW'(1);
            for (int i = 0; i < N; i++) begin
                r_xsh[i] <= r_xsh[i] >> 1;
                r_acc[i] <= w_acc_nxt[i];
                if (w_last) r_y[i] <= w_acc_nxt[i];
            end
        end
    end

    // A write coinciding with an accepted start lands on the same edge, before the first plane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                for (int i = 0; i < N; i++) begin
                    r_coef[k][i] <= (k == i) ? CW'(1) : CW'(0);
                end
            end
        end else if (bus.coef_we && (r_state != S_SHIFT)) begin
            r_coef[bus.coef_row][bus.coef_col] <= bus.coef_data;
        end
    end

    assign bus.busy      = (r_state == S_SHIFT);
    assign bus.done      = (r_state == S_DONE);
    assign bus.dbg_state = r_state;

    always_comb begin
        bus.y_out = '0;
        for (int k = 0; k < N; k++) bus.y_out[k*YW +: YW] = r_y[k];
    end
endmodule

// File: tb/tb_da_matvec_param.sv
// Bench for da_matvec_param: integer model of Y = D*X feeding an expected-result queue,
// compared against y_out whenever done rises.
`timescale 1ns/1ps
module tb_da_matvec_param;
    localparam int N  = 8;
    localparam int XW = 8;
    localparam int CW = 4;
    localparam int YW = XW + CW + $clog2(N);
    localparam int RW = $clog2(N);
    localparam int VW = N * YW;
`ifdef DA_LUTREG_EN
    localparam int LAT = XW + 1;
`else
    localparam int LAT = XW;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;
    int   e0 = 0;
    int   m_d [N][N];
    int   xv  [N];
    logic [VW-1:0] exp_q [$];

    da_matvec_param_if #(.N(N), .XW(XW), .CW(CW)) bus ();

    da_matvec_param #(.N(N), .XW(XW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- checking / model ----------------
    task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] model_y();
        logic [VW-1:0] v;
        int acc;
        v = '0;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int i = 0; i < N; i++) acc += m_d[k][i] * xv[i];
            v[k*YW +: YW] = acc[YW-1:0];
        end
        return v;
    endfunction

    function automatic logic [N*XW-1:0] pack_x();
        logic [N*XW-1:0] v;
        int t;
        v = '0;
        for (int i = 0; i < N; i++) begin
            t = xv[i];
            v[i*XW +: XW] = t[XW-1:0];
        end
        return v;
    endfunction

    task automatic set_identity();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) m_d[k][i] = (k == i) ? 1 : 0;
    endtask

    task automatic rand_x();
        for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    // ---------------- drivers ----------------
    task automatic wr_coef(input int k, input int i, input int d);
        @(negedge clk);
        bus.coef_we   = 1'b1;
        bus.coef_row  = RW'(k);
        bus.coef_col  = RW'(i);
        bus.coef_data = CW'(d);
        @(negedge clk);
        bus.coef_we = 1'b0;
        m_d[k][i] = d;
    endtask

    task automatic start_op(input bit we, input int k, input int i, input int d);
        @(negedge clk);
        bus.x_in  = pack_x();
        bus.start = 1'b1;
        if (we) begin
            bus.coef_we   = 1'b1;
            bus.coef_row  = RW'(k);
            bus.coef_col  = RW'(i);
            bus.coef_data = CW'(d);
            m_d[k][i] = d;
        end
        exp_q.push_back(model_y());
        @(negedge clk);
        bus.start   = 1'b0;
        bus.coef_we = 1'b0;
        bus.x_in    = ~bus.x_in;
        e0 = edge_cnt;
        check("busy_after_start", VW'(bus.busy), VW'(1));
        check("done_after_start", VW'(bus.done), VW'(0));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, VW'(bus.done), VW'(1));
        check({tag, "_latency"}, VW'(edge_cnt - e0), VW'(LAT));
        check({tag, "_busy_low"}, VW'(bus.busy), VW'(0));
        check({tag, "_sb_depth"}, VW'(exp_q.size()), VW'(1));
        if (exp_q.size() > 0) check({tag, "_y"}, bus.y_out, exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [YW-1:0] want;
        bus.start = 1'b0;
        bus.x_in = '0;
        bus.coef_we = 1'b0;
        bus.coef_row = '0;
        bus.coef_col = '0;
        bus.coef_data = '0;
        set_identity();
        repeat (3) @(negedge clk);
        check("rst_busy", VW'(bus.busy), VW'(0));
        check("rst_done", VW'(bus.done), VW'(0));
        check("rst_y", bus.y_out, VW'(0));
        reset = 1'b1;
        @(negedge clk);
        check("idle_state", VW'(bus.dbg_state), VW'(0));

        xv = '{1, -1, 127, -128, 0, 5, -5, 2};
        start_op(1'b0, 0, 0, 0);
        wait_done("identity");

        for (int i = 0; i < N; i++) wr_coef(0, i, -8);
        for (int i = 0; i < N; i++) xv[i] = -128;
        start_op(1'b0, 0, 0, 0);
        wait_done("fullscale");
        want = YW'(8192);
        check("y0_fullscale", VW'(bus.y_out[YW-1:0]), VW'(want));
        for (int i = 0; i < N; i++) wr_coef(0, i, (i == 0) ? 1 : 0);

        wr_coef(3, 5, 7);
        wr_coef(3, 3, -8);
        for (int i = 0; i < N; i++) xv[i] = 0;
        xv[3] = 10;
        xv[5] = -3;
        start_op(1'b0, 0, 0, 0);
        wait_done("sparse");
        want = YW'(-101);
        check("y3_sparse", VW'(bus.y_out[3*YW +: YW]), VW'(want));
        wr_coef(3, 5, 0);
        wr_coef(3, 3, 1);

        rand_x();
        start_op(1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.coef_we = 1'b1;
        bus.coef_row = '0;
        bus.coef_col = '0;
        bus.coef_data = CW'(-1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.coef_we = 1'b0;
        wait_done("mid_shift_ignored");
        for (int i = 0; i < N; i++) xv[i] = 0;
        xv[0] = 37;
        start_op(1'b0, 0, 0, 0);
        wait_done("after_dropped_write");
        want = YW'(37);
        check("y0_still_one", VW'(bus.y_out[YW-1:0]), VW'(want));

        wr_coef(1, 2, 5);
        rand_x();
        start_op(1'b0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", VW'(bus.busy), VW'(0));
        check("abort_done", VW'(bus.done), VW'(0));
        check("abort_y", bus.y_out, VW'(0));
        check("abort_state", VW'(bus.dbg_state), VW'(0));
        exp_q.delete();
        set_identity();
        @(negedge clk);
        reset = 1'b1;
        rand_x();
        xv[2] = 100;
        start_op(1'b0, 0, 0, 0);
        wait_done("post_reset");

        for (int i = 0; i < N; i++) xv[i] = 0;
        xv[2] = 11;
        start_op(1'b1, 2, 2, 3);
        wait_done("write_with_start");
        want = YW'(33);
        check("y2_write_with_start", VW'(bus.y_out[2*YW +: YW]), VW'(want));

        for (int r = 0; r < 4; r++) begin
            repeat (3) wr_coef(int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)),
                               int'($urandom_range(0, 15)) - 8);
            rand_x();
            start_op(1'b0, 0, 0, 0);
            wait_done("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
